// File: rtl/alu_result_fifo.sv
// alu_result_fifo: buffers ALU results {s, overflow, zero, ctrl} in a small FIFO
// and keeps saturating overflow/zero statistics. Optional parity: ALU_RESULT_PARITY_EN.
module alu_result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_s,
    input  logic                       in_overflow,
    input  logic                       in_zero,
    input  logic [3:0]                 in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_s,
    output logic                       out_overflow,
    output logic                       out_zero,
    output logic [3:0]                 out_ctrl,
`ifdef ALU_RESULT_PARITY_EN
    output logic                       out_parity_err,
`endif
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           ovf_count,
    output logic [CNT_W-1:0]           zero_count,
    input  logic                       clr_stats
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem_s_q   [DEPTH];
    logic              mem_ovf_q [DEPTH];
    logic              mem_zero_q[DEPTH];
    logic [3:0]        mem_ctrl_q[DEPTH];
`ifdef ALU_RESULT_PARITY_EN
    logic              mem_par_q [DEPTH];
`endif

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

    logic full, empty, push, pop;

    // Handshake: a beat transfers on a rising edge where valid && ready. in_ready
    // is !full with no pass-through from pop, so a full FIFO refuses a push even
    // when a pop happens in that same cycle; out_valid is !empty with no bypass.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = in_valid & ~full;
    assign pop   = out_ready & ~empty;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign level     = wr_ptr_q - rd_ptr_q;

    assign out_s        = mem_s_q[rd_ptr_q[AW-1:0]];
    assign out_overflow = mem_ovf_q[rd_ptr_q[AW-1:0]];
    assign out_zero     = mem_zero_q[rd_ptr_q[AW-1:0]];
    assign out_ctrl     = mem_ctrl_q[rd_ptr_q[AW-1:0]];
`ifdef ALU_RESULT_PARITY_EN
    assign out_parity_err = out_valid & ((^out_s) ^ mem_par_q[rd_ptr_q[AW-1:0]]);
`endif

    assign ovf_count  = ovf_cnt_q;
    assign zero_count = zero_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_cnt_d  = ovf_cnt_q;
        zero_cnt_d = zero_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        // Clear wins over a same-cycle increment; counters stick at all-ones.
        if (clr_stats) begin
            ovf_cnt_d  = '0;
            zero_cnt_d = '0;
        end else if (push) begin
            if (in_overflow && ovf_cnt_q != CNT_MAX) ovf_cnt_d  = ovf_cnt_q + 1'b1;
            if (in_zero && zero_cnt_q != CNT_MAX)    zero_cnt_d = zero_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_cnt_q  <= '0;
            zero_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_cnt_q  <= ovf_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_s_q[i]    <= '0;
                mem_ovf_q[i]  <= 1'b0;
                mem_zero_q[i] <= 1'b0;
                mem_ctrl_q[i] <= '0;
`ifdef ALU_RESULT_PARITY_EN
                mem_par_q[i]  <= 1'b0;
`endif
            end
        end else if (push) begin
            mem_s_q[wr_ptr_q[AW-1:0]]    <= in_s;
            mem_ovf_q[wr_ptr_q[AW-1:0]]  <= in_overflow;
            mem_zero_q[wr_ptr_q[AW-1:0]] <= in_zero;
            mem_ctrl_q[wr_ptr_q[AW-1:0]] <= in_ctrl;
`ifdef ALU_RESULT_PARITY_EN
            mem_par_q[wr_ptr_q[AW-1:0]]  <= ^in_s;
`endif
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, fill/drop, drain order, streaming
// with pointer wrap, statistics saturation and clear.
module tb_alu_result_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_s;
    logic              in_overflow;
    logic              in_zero;
    logic [3:0]        in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_s;
    logic              out_overflow;
    logic              out_zero;
    logic [3:0]        out_ctrl;
`ifdef ALU_RESULT_PARITY_EN
    logic              out_parity_err;
`endif
    logic [2:0]        level;
    logic [CNT_W-1:0]  ovf_count;
    logic [CNT_W-1:0]  zero_count;
    logic              clr_stats;

    int n_vec  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_s;

    alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_s(in_s),
        .in_overflow(in_overflow),
        .in_zero(in_zero),
        .in_ctrl(in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s(out_s),
        .out_overflow(out_overflow),
        .out_zero(out_zero),
        .out_ctrl(out_ctrl),
`ifdef ALU_RESULT_PARITY_EN
        .out_parity_err(out_parity_err),
`endif
        .level(level),
        .ovf_count(ovf_count),
        .zero_count(zero_count),
        .clr_stats(clr_stats)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] s, input logic ovf,
                         input logic z, input logic [3:0] c);
        in_valid    = v;
        in_s        = s;
        in_overflow = ovf;
        in_zero     = z;
        in_ctrl     = c;
    endtask

    task automatic expect_head(input string tag, input logic [15:0] s, input logic ovf,
                               input logic z, input logic [3:0] c);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_s"},     {16'd0, out_s}, {16'd0, s});
        check({tag, "_ovf"},   {31'd0, out_overflow}, {31'd0, ovf});
        check({tag, "_zero"},  {31'd0, out_zero}, {31'd0, z});
        check({tag, "_ctrl"},  {28'd0, out_ctrl}, {28'd0, c});
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0);
        #12 rst_n = 1'b1;
        tick();

        // reset state
        check("rst_level",  {29'd0, level}, 32'd0);
        check("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check("rst_iready", {31'd0, in_ready}, 32'd1);
        check("rst_ovf",    {24'd0, ovf_count}, 32'd0);
        check("rst_zero",   {24'd0, zero_count}, 32'd0);
        check("rst_out_s",  {16'd0, out_s}, 32'd0);

        // async reset mid-operation at level 3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h00A0 + 16'(i), 1'b1, 1'b1, 4'h1);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0);
        check("pre_async_level", {29'd0, level}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_level",  {29'd0, level}, 32'd0);
        check("async_ovalid", {31'd0, out_valid}, 32'd0);
        check("async_ovf",    {24'd0, ovf_count}, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // fill with out_ready low
        drive(1'b1, 16'h0035, 1'b0, 1'b0, 4'h2); tick();
        check("fill1_level", {29'd0, level}, 32'd1);
        expect_head("fill1_head", 16'h0035, 1'b0, 1'b0, 4'h2);
        drive(1'b1, 16'h0FBC, 1'b0, 1'b0, 4'h3); tick();
        drive(1'b1, 16'h0000, 1'b0, 1'b1, 4'h4); tick();
        drive(1'b1, 16'h7FFF, 1'b1, 1'b0, 4'h5); tick();
        check("full_level",  {29'd0, level}, 32'd4);
        check("full_iready", {31'd0, in_ready}, 32'd0);
        // 5th push must be dropped, and must not count
        drive(1'b1, 16'h1234, 1'b1, 1'b1, 4'h6); tick();
        check("drop_level", {29'd0, level}, 32'd4);
        check("drop_zcnt",  {24'd0, zero_count}, 32'd1);
        check("drop_ocnt",  {24'd0, ovf_count}, 32'd1);
        expect_head("hold_head", 16'h0035, 1'b0, 1'b0, 4'h2);

        // first pop while full with push offered: push refused
        out_ready = 1'b1;
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0);
        check("fullpop_level", {29'd0, level}, 32'd3);
        check("fullpop_iready", {31'd0, in_ready}, 32'd1);
        expect_head("drain2", 16'h0FBC, 1'b0, 1'b0, 4'h3); tick();
        expect_head("drain3", 16'h0000, 1'b0, 1'b1, 4'h4); tick();
        expect_head("drain4", 16'h7FFF, 1'b1, 1'b0, 4'h5); tick();
        check("drained_level",  {29'd0, level}, 32'd0);
        check("drained_ovalid", {31'd0, out_valid}, 32'd0);
        check("drained_iready", {31'd0, in_ready}, 32'd1);
        check("drained_zcnt",   {24'd0, zero_count}, 32'd1);

        // streaming at level 2 with pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 4'(i));
            exp_q.push_back(16'hA000 + 16'(i));
            tick();
        end
        check("stream_pre_level", {29'd0, level}, 32'd2);
        out_ready = 1'b1;
        for (int k = 2; k < 22; k++) begin
            drive(1'b1, 16'hA000 + 16'(k), 1'b0, 1'b0, 4'(k));
            exp_s = exp_q.pop_front();
            check("stream_s", {16'd0, out_s}, {16'd0, exp_s});
            exp_q.push_back(16'hA000 + 16'(k));
            tick();
            check("stream_level", {29'd0, level}, 32'd2);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            check("stream_tail_s", {16'd0, out_s}, {16'd0, exp_s});
            tick();
        end
        check("stream_end_level", {29'd0, level}, 32'd0);

        // overflow counter saturation: starts at 1, +300 -> stuck at 255
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'h8000, 1'b1, 1'b0, 4'h7);
            tick();
        end
        check("sat_ovf",  {24'd0, ovf_count}, 32'd255);
        check("sat_zero", {24'd0, zero_count}, 32'd1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_ovf",  {24'd0, ovf_count}, 32'd0);
        check("clr_zero", {24'd0, zero_count}, 32'd0);
        tick();
        check("post_clr_ovf", {24'd0, ovf_count}, 32'd1);

`ifdef ALU_RESULT_PARITY_EN
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0);
        repeat (3) tick();
        out_ready = 1'b0;
        drive(1'b1, 16'h5555, 1'b0, 1'b0, 4'h1); tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0);
        check("par_5555", {31'd0, out_parity_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 16-bit ALU (alu_control). Captures each ALU result {s, overflow, zero} together with the ctrl code that produced it.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Keeps saturating statistics (overflow and zero-result counts) for the writeback/debug logic that consumes ALU output.

Parameters:
- DATA_W, 16: ALU result width; matches the s output of alu_control.
- DEPTH, 4: FIFO entries; must be a power of two, minimum 2.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  ALU result presented.
- in_ready  output  1  FIFO can accept; equals !full.
- in_s  input  DATA_W  ALU result s.
- in_overflow  input  1  ALU overflow flag.
- in_zero  input  1  ALU zero flag.
- in_ctrl  input  4  ALU ctrl code used for this result.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer accepts head.
- out_s  output  DATA_W  head result.
- out_overflow  output  1  head overflow flag.
- out_zero  output  1  head zero flag.
- out_ctrl  output  4  head ctrl code.
- level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- ovf_count  output  CNT_W  accepted entries with overflow=1, saturating.
- zero_count  output  CNT_W  accepted entries with zero=1, saturating.
- clr_stats  input  1  synchronous clear of ovf_count and zero_count.

Behaviour:
- Reset (rst_n=0, async): rd_ptr=0, wr_ptr=0, level=0, out_valid=0, in_ready=1, ovf_count=0, zero_count=0. out_s, out_overflow, out_zero and out_ctrl all read 0; storage is cleared on reset.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated at the rising edge of clk.
- Latency: an entry pushed at edge N drives out_* and out_valid=1 after edge N. No same-cycle bypass when empty.
- out_* are driven combinationally from storage at rd_ptr. They must hold stable while out_valid=1 and out_ready=0.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally. full and empty are decoded from the extra MSB.
- Simultaneous push and pop (0 < level < DEPTH): both occur and level is unchanged.
- When full, in_ready=0, so a push is refused even if a pop happens in the same cycle; in_ready rises the cycle after the pop.
- When empty, out_valid=0 and out_ready is ignored.
- in_valid while in_ready=0: the data is not captured. The producer must hold it; the FIFO asserts no requirement on that.
- Statistics update only on push:
  - ovf_count += in_overflow, zero_count += in_zero.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- clr_stats=1 zeroes both counters at the next edge and takes priority over a same-cycle increment.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed as XOR of in_s at push.
  - Output port out_parity_err (1 bit) = XOR of out_s XOR stored parity, gated by out_valid.
  - Reset value 0.
- Undefined: no parity storage, and port out_parity_err is absent.

Test Plan:
- Reset then idle -> level=0, out_valid=0, in_ready=1, counters 0. Assert rst_n=0 while level=3 -> level=0 and out_valid=0 immediately.
- Push s=16'h0035/ctrl=2, then 16'h0FBC, 16'h0000 (zero=1), 16'h7FFF (overflow=1) with out_ready=0:
  - -> level=4, in_ready=0.
  - A 5th push of 16'h1234 is dropped.
  - zero_count=1, ovf_count=1.
- Drain with out_ready=1 -> out_s sequence 0035, 0FBC, 0000, 7FFF with matching flags and ctrl. level reaches 0 and out_valid falls after the 4th pop.
- Continuous push+pop every cycle for 20 cycles at level=2 -> level stays 2, data order preserved. Pointers wrap at least 4 times with no loss.
- 300 pushes with overflow=1 -> ovf_count holds 255. clr_stats pulsed together with a push -> ovf_count=0 next cycle.
- With ALU_RESULT_PARITY_EN: push 16'h5555 -> out_parity_err=0. Force-corrupt the stored parity -> out_parity_err=1 while the entry is at head.
